// File: rtl/rom_fetch_pkg.sv
// Shared constants and types for the ROM instruction fetch front end.
package rom_fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] ARM_NOP = 32'hE1A00000;
  localparam int FETCH_DATA_WIDTH = 32;

  typedef struct packed {
    logic [31:0]                 pc;
    logic [FETCH_DATA_WIDTH-1:0] data;
  } fetch_entry_t;

  // Instructions are word aligned, so the low two PC bits never matter.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rom_fetch_unit_fifo.sv
// Small synchronous FIFO with a flush that wins over a same-cycle push.
module fetch_fifo
  import rom_fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rom_fetch_unit.sv
// Fetch front end: drives ROM word addresses, absorbs the 1-cycle ROM latency
// and buffers {pc, instruction} pairs for decode.
module rom_fetch_unit
  import rom_fetch_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [31:0]           instr_pc
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int USED_W  = CNT_W + 1;
  localparam int ENTRY_W = 32 + DATA_WIDTH;

  logic [31:0]         fetch_pc;
  logic [31:0]         inflight_pc;
  logic                inflight;
  logic                squash;
  logic                pop;
  logic                push;
  logic                issue;
  logic [USED_W-1:0]   used;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  fifo_head;

  // instr_valid/instr_ready: an entry transfers on any cycle where both are
  // high; while valid is high and ready is low the head (data and pc) is held.
  assign pop = instr_valid && instr_ready;

  // A read is issued only if its word is guaranteed a slot when it returns:
  // slots after this cycle = buffered + the word landing now - the one leaving.
  assign used  = USED_W'(fifo_count) + USED_W'(inflight) - USED_W'(pop);
  assign issue = fetch_en && !redirect_valid
              && (used < USED_W'(FIFO_DEPTH))
              && (!fifo_full || pop);

  assign push     = inflight && !squash;
  assign rom_addr = fetch_pc[ADDR_WIDTH+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      squash      <= 1'b0;
    end else begin
      squash <= redirect_valid && inflight;
      if (redirect_valid) begin
        fetch_pc <= align_pc(redirect_pc);
        inflight <= 1'b0;
      end else if (issue) begin
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'(INSTR_BYTES);
      end else begin
        inflight <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({inflight_pc, rom_dout}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Outputs read as zero while nothing is buffered, including out of reset.
  assign instr_valid            = !fifo_empty;
  assign {instr_pc, instr_data} = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Bench for rom_fetch_unit: directed latency/stall/redirect/wrap/reset steps,
// then randomized traffic, all checked against a sequential-stream model.
module tb_rom_fetch_unit;
  import rom_fetch_pkg::*;

  localparam int          DW       = 32;
  localparam int          AW       = 10;
  localparam logic [31:0] RESET_PC = 32'h00000000;

  logic          clk;
  logic          rst;
  logic          fetch_en;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr_data;
  logic [31:0]   instr_pc;

  rom_fetch_unit #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_dout       (rom_dout),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  // ---------------- clock / ROM ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] rom_mem [1 << AW];
  always @(posedge clk) rom_dout <= rom_mem[rom_addr];

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int pops   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // The delivered stream must be consecutive word PCs from the latest reset or
  // redirect target, each paired with the ROM word at that PC.
  localparam int ENTRY_W = $bits(fetch_entry_t);
  logic [ENTRY_W-1:0] exp_q[$];
  logic [31:0]        gen_pc;
  logic               prev_stall;
  logic [DW-1:0]      prev_data;
  logic [31:0]        prev_pc;

  function automatic logic [ENTRY_W-1:0] entry_for(input logic [31:0] pc);
    return {pc, rom_mem[pc[AW+1:2]]};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      gen_pc     = RESET_PC;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(instr_valid), 64'd1);
        check("hold_entry", {instr_pc, instr_data}, {prev_pc, prev_data});
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          exp_q.push_back(entry_for(gen_pc));
          gen_pc = gen_pc + 32'd4;
        end
        check("entry", {instr_pc, instr_data}, exp_q.pop_front());
        pops++;
      end
      prev_stall = instr_valid && !instr_ready;
      prev_data  = instr_data;
      prev_pc    = instr_pc;
      if (redirect_valid) begin
        exp_q.delete();
        gen_pc     = {redirect_pc[31:2], 2'b00};
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [AW-1:0] stall_addr;
  logic          found;

  initial begin
    rst            = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    for (int i = 0; i < (1 << AW); i++)
      rom_mem[i] = ARM_NOP ^ (($urandom & 32'hFFFFFC00) | 32'(i));

    repeat (3) tick();
    sample();
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_data",  64'(instr_data),  64'd0);
    check("rst_pc",    64'(instr_pc),    64'd0);
    check("rst_addr",  64'(rom_addr),    64'(RESET_PC[AW+1:2]));

    // Latency from reset release, then gap-free streaming.
    tick(); rst = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
    sample();
    check("lat_c1_valid", 64'(instr_valid), 64'd0);
    check("lat_c1_addr",  64'(rom_addr),    64'd0);
    tick(); sample();
    check("lat_c2_valid", 64'(instr_valid), 64'd0);
    check("lat_c2_addr",  64'(rom_addr),    64'd1);
    tick(); sample();
    check("lat_c3_valid", 64'(instr_valid), 64'd1);
    check("lat_c3_pc",    64'(instr_pc),    64'(RESET_PC));
    for (int i = 0; i < 16; i++) begin
      tick(); sample();
      check("stream_gap", 64'(instr_valid), 64'd1);
    end

    // Stall: the fetch address must freeze while the head holds.
    tick(); instr_ready = 1'b0;
    sample();
    stall_addr = rom_addr;
    for (int i = 0; i < 9; i++) begin
      tick(); sample();
      check("stall_addr", 64'(rom_addr), 64'(stall_addr));
    end

    // Redirect while the buffer is full.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h100;
    sample();
    tick(); redirect_valid = 1'b0; instr_ready = 1'b1;
    sample();
    check("redir_n1_valid", 64'(instr_valid), 64'd0);
    tick(); sample();
    check("redir_n2_valid", 64'(instr_valid), 64'd0);
    tick(); sample();
    check("redir_n3_valid", 64'(instr_valid), 64'd1);
    check("redir_n3_pc",    64'(instr_pc),    64'h100);
    check("redir_n3_data",  64'(instr_data),  64'(rom_mem[64]));
    repeat (6) begin tick(); sample(); end

    // Redirect alongside a pop, then a second redirect straight after.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h40;
    sample();
    check("pop_at_redir", 64'(instr_valid), 64'd1);
    tick(); redirect_pc = 32'h80;
    sample();
    check("b2b_flushed", 64'(instr_valid), 64'd0);
    tick(); redirect_valid = 1'b0;
    sample();
    check("b2b_n1_valid", 64'(instr_valid), 64'd0);
    tick(); sample();
    check("b2b_n2_valid", 64'(instr_valid), 64'd0);
    tick(); sample();
    check("b2b_n3_valid", 64'(instr_valid), 64'd1);
    check("b2b_n3_pc",    64'(instr_pc),    64'h80);

    // fetch_en 1-0-1: drains, then resumes sequentially.
    repeat (4) begin tick(); sample(); end
    tick(); fetch_en = 1'b0;
    sample();
    repeat (4) begin tick(); sample(); end
    check("fe_off_drained", 64'(instr_valid), 64'd0);
    tick(); fetch_en = 1'b1;
    sample();
    repeat (5) begin tick(); sample(); end

    // ROM address wrap at the top of the 4 KiB window.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFF8;
    sample();
    tick(); redirect_valid = 1'b0;
    sample();
    check("wrap_addr0", 64'(rom_addr), 64'h3FE);
    tick(); sample();
    check("wrap_addr1", 64'(rom_addr), 64'h3FF);
    tick(); sample();
    check("wrap_addr2", 64'(rom_addr), 64'h000);
    check("wrap_pc",    64'(instr_pc), 64'hFF8);
    repeat (4) begin tick(); sample(); end

    // 32-bit PC wrap; low redirect bits are ignored.
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFB;
    sample();
    tick(); redirect_valid = 1'b0;
    sample();
    tick(); sample();
    tick(); sample();
    check("pc32_first", 64'(instr_pc), 64'hFFFFFFF8);
    repeat (4) begin tick(); sample(); end

    // Asynchronous reset mid-stream with data buffered and a read in flight.
    tick(); instr_ready = 1'b0;
    #2; rst = 1'b1;
    #1;
    check("arst_valid", 64'(instr_valid), 64'd0);
    check("arst_data",  64'(instr_data),  64'd0);
    check("arst_pc",    64'(instr_pc),    64'd0);
    check("arst_addr",  64'(rom_addr),    64'(RESET_PC[AW+1:2]));
    sample();
    tick(); rst = 1'b0; instr_ready = 1'b1;
    sample();
    check("arst_c1_valid", 64'(instr_valid), 64'd0);
    tick(); sample();
    check("arst_c2_valid", 64'(instr_valid), 64'd0);
    tick(); sample();
    check("arst_c3_valid", 64'(instr_valid), 64'd1);
    check("arst_c3_pc",    64'(instr_pc),    64'(RESET_PC));

    // Randomized traffic.
    pops = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      fetch_en       = ($urandom_range(0, 9) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = $urandom;
      sample();
    end
    check("rand_progress", 64'(pops > 200), 64'd1);

    // Bounded wait for the stream to come back after the random phase.
    tick(); redirect_valid = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      sample();
      if (instr_valid) found = 1'b1;
      else tick();
    end
    check("final_live", 64'(found), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
